mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM).
- Arbitrates between the two requesters with round-robin priority (data first after reset) and runs one memory transaction at a time through a req/ack handshake.
- Returns read data to the requester and drives per-port stall signals that freeze the PC, the IF/ID register and the downstream pipe registers while a port waits.
- Includes a sticky timeout flag for a memory that never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 1024, cycles `mem_req_o` may stay high without `mem_ack_i` before `err_timeout_o` sets (≥2).

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  instruction read request; held high until `if_done_o`.
- if_addr_i  in  ADDR_W  fetch address; stable while `if_req_i` is high.
- if_rdata_o  out  DATA_W  fetched instruction; registered, valid when `if_done_o` is high, held until the next IF completion.
- if_done_o  out  1  one-cycle completion pulse.
- if_stall_o  out  1  `if_req_i & ~if_done_o` (combinational).
- dm_req_i  in  1  data request; held high until `dm_done_o`.
- dm_we_i  in  1  1 = write, 0 = read; stable with the request.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_rdata_o  out  DATA_W  read data; registered, updated only on read completion.
- dm_done_o  out  1  one-cycle completion pulse (reads and writes).
- dm_stall_o  out  1  `dm_req_i & ~dm_done_o` (combinational).
- mem_req_o  out  1  memory request; registered, held until ack.
- mem_we_o  out  1  write enable for the current transaction.
- mem_addr_o  out  ADDR_W  latched transaction address.
- mem_wdata_o  out  DATA_W  latched write data.
- mem_ack_i  in  1  memory completion. For a read, `mem_rdata_i` is valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- err_timeout_o  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.

IDLE:
- A port is eligible when its req is high and its done output is low this cycle. This suppresses the stale request in the same cycle as its done pulse.
- Only data eligible → latch `dm_addr_i`/`dm_wdata_i`/`dm_we_i` into `mem_*`, set `mem_req_o`, go to BUSY_D.
- Only IF eligible → latch `if_addr_i`, set `mem_we_o` to 0, set `mem_req_o`, go to BUSY_I.
- Both eligible → grant the port not served last, using flag `last_d` (1 = last grant was data); `last_d` resets to 0, so the first tie goes to data. On a tie, `last_d = 1` grants IF and `last_d = 0` grants data.
- Update `last_d` on every grant.

BUSY_I / BUSY_D:
- Hold `mem_*` stable.
- On `mem_ack_i`: clear `mem_req_o`, pulse the matching done output next cycle, capture `mem_rdata_i` into `if_rdata_o` (BUSY_I) or into `dm_rdata_o` (BUSY_D with `mem_we_o` = 0), return to IDLE.
- `mem_ack_i` in IDLE is ignored.
- A requester dropping req mid-transaction is illegal; the transaction still completes and done still pulses.

Timeout:
- A wait counter clears on every grant and increments each BUSY cycle without ack.
- The counter reaching TIMEOUT−1 sets `err_timeout_o`. The FSM keeps waiting; the transaction is not abandoned.
- The counter saturates and does not wrap.

Reset (any time, including mid-transaction):
- State → IDLE; `mem_req_o`, `mem_we_o`, both done outputs, `err_timeout_o`, `last_d` and the counter → 0.
- `mem_addr_o`, `mem_wdata_o`, `if_rdata_o`, `dm_rdata_o` → 0.
- The in-flight transaction is abandoned.

## Timing
- Minimum latency from a request sampled in IDLE at cycle 0:
  - `mem_req_o` high in cycle 1.
  - Ack in cycle 1 → done high and rdata valid in cycle 2.
  - Next grant decided in cycle 2; `mem_req_o` high again in cycle 3.
- Sustained throughput: at most one transaction per 2 cycles plus memory wait.
- Stall outputs are combinational from `req_i` and the registered done, so there is no extra cycle on release.
- Simultaneous requests in IDLE: one grant per cycle; the loser's stall stays high until its own done.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY_I, BUSY_D};
  - localparams for the round-robin encoding (`GRANT_IF`, `GRANT_DM`).
- Sub-module `arb_wait_timer`: saturating counter with clear, enable and a `hit` output at TIMEOUT−1, parameterised on TIMEOUT.
- All other logic lives in the top module.

## Test plan
- Reset, then IF read of 0x0000_0010 with ack in the first `mem_req_o` cycle → `mem_addr_o` = 0x10 in cycle 1, `if_done_o` in cycle 2 with `if_rdata_o` = `mem_rdata_i` value 0x2001_0005; `if_stall_o` high in cycles 0–1.
- IF and data requests in the same cycle after reset → data granted first; IF granted on the next IDLE cycle. Both requests again after that → data granted (`last_d` alternates).
- Data write addr 0x40, wdata 0xDEAD_BEEF, ack after 3 wait cycles → `mem_we_o` = 1, `mem_wdata_o` = 0xDEADBEEF for 4 cycles, `dm_done_o` pulses once, `dm_rdata_o` unchanged.
- Requester holds req high through its done cycle and drops it next → exactly one transaction issued, no duplicate `mem_req_o`.
- TIMEOUT = 8, memory never acks → `err_timeout_o` rises after 8 BUSY cycles and stays high. Assert reset mid-transaction → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and grant encoding for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  // Encoding of the round-robin flag: the value stored is the port granted last.
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating wait counter; hit is high once the count has reached TIMEOUT-1.
module arb_wait_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  assign hit = (cnt_q == CntMax);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IF and MEM stages.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_timeout_o
);

  arb_state_t state_q;
  logic       last_d_q;
  logic       if_elig, dm_elig;
  logic       grant, grant_sel;
  logic       busy, hit;

  // A port in its done cycle still shows its stale request; mask it out.
  assign if_elig    = if_req_i & ~if_done_o;
  assign dm_elig    = dm_req_i & ~dm_done_o;
  assign if_stall_o = if_req_i & ~if_done_o;
  assign dm_stall_o = dm_req_i & ~dm_done_o;

  assign busy      = (state_q != IDLE);
  assign grant     = (state_q == IDLE) & (if_elig | dm_elig);
  assign grant_sel = (dm_elig & (~if_elig | (last_d_q == GRANT_IF))) ? GRANT_DM : GRANT_IF;

  arb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (grant),
    .en   (busy & ~mem_ack_i),
    .hit  (hit)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      last_d_q      <= GRANT_IF;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      if_done_o     <= 1'b0;
      dm_done_o     <= 1'b0;
      if_rdata_o    <= '0;
      dm_rdata_o    <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      if_done_o <= 1'b0;
      dm_done_o <= 1'b0;
      // The transaction keeps waiting after a timeout; the flag only reports it.
      if (busy && !mem_ack_i && hit) begin
        err_timeout_o <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            last_d_q  <= grant_sel;
            mem_req_o <= 1'b1;
            if (grant_sel == GRANT_DM) begin
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              mem_we_o    <= dm_we_i;
              state_q     <= BUSY_D;
            end else begin
              mem_addr_o <= if_addr_i;
              mem_we_o   <= 1'b0;
              state_q    <= BUSY_I;
            end
          end
        end
        BUSY_I: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            if_done_o  <= 1'b1;
            if_rdata_o <= mem_rdata_i;
            state_q    <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            dm_done_o <= 1'b1;
            if (!mem_we_o) begin
              dm_rdata_o <= mem_rdata_i;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [AW-1:0] if_addr_i, dm_addr_i;
  logic [DW-1:0] dm_wdata_i, mem_rdata_i;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_done_o, if_stall_o, dm_done_o, dm_stall_o;
  logic          mem_req_o, mem_we_o, err_timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_rdata_o   (if_rdata_o),
    .if_done_o    (if_done_o),
    .if_stall_o   (if_stall_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_rdata_o   (dm_rdata_o),
    .dm_done_o    (dm_done_o),
    .dm_stall_o   (dm_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_timeout_o(err_timeout_o)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 0;
    step();
    step();
    rst_i = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 0;
    #3;
    tests++;
    if ({mem_req_o, mem_we_o, if_done_o, dm_done_o, err_timeout_o, if_stall_o, dm_stall_o} !== 7'b0
        || mem_addr_o !== '0 || mem_wdata_o !== '0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
      fails++;
      $display("FAIL reset_state: req=%b we=%b done=%b%b err=%b addr=%h wdata=%h rd=%h/%h want all 0",
               mem_req_o, mem_we_o, if_done_o, dm_done_o, err_timeout_o, mem_addr_o, mem_wdata_o,
               if_rdata_o, dm_rdata_o);
    end
    @(negedge clk);
    rst_i = 1;
  endtask

  task automatic test_if_read();
    apply_reset();
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    #1;
    tests++;
    if (if_stall_o !== 1'b1) begin fails++; $display("FAIL if_read_stall_c0: got %b want 1", if_stall_o); end
    step();
    tests++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0 || if_stall_o !== 1'b1
        || if_done_o !== 1'b0) begin
      fails++;
      $display("FAIL if_read_c1: req=%b addr=%h we=%b stall=%b done=%b want 1 10 0 1 0",
               mem_req_o, mem_addr_o, mem_we_o, if_stall_o, if_done_o);
    end
    mem_ack_i = 1; mem_rdata_i = 32'h2001_0005;
    step();
    tests++;
    if (mem_req_o !== 1'b0 || if_done_o !== 1'b1 || if_rdata_o !== 32'h2001_0005 || if_stall_o !== 1'b0) begin
      fails++;
      $display("FAIL if_read_c2: req=%b done=%b rdata=%h stall=%b want 0 1 20010005 0",
               mem_req_o, if_done_o, if_rdata_o, if_stall_o);
    end
    if_req_i = 0; mem_ack_i = 0; mem_rdata_i = '0;
    step();
    tests++;
    if (if_done_o !== 1'b0 || mem_req_o !== 1'b0 || if_rdata_o !== 32'h2001_0005) begin
      fails++;
      $display("FAIL if_read_c3: done=%b req=%b rdata=%h want 0 0 20010005", if_done_o, mem_req_o, if_rdata_o);
    end
  endtask

  task automatic test_tie_rr();
    logic [AW-1:0] exp_addr [3];
    logic          exp_dm [3];
    exp_addr[0] = 32'h200; exp_dm[0] = 1;
    exp_addr[1] = 32'h100; exp_dm[1] = 0;
    exp_addr[2] = 32'h400; exp_dm[2] = 1;
    apply_reset();
    if_req_i = 1; if_addr_i = 32'h100; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        if_req_i = 1; if_addr_i = 32'h300; dm_req_i = 1; dm_addr_i = 32'h400;
      end
      step();
      tests++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr[k]) begin
        fails++;
        $display("FAIL tie_grant_%0d: req=%b addr=%h want 1 %h", k, mem_req_o, mem_addr_o, exp_addr[k]);
      end
      mem_ack_i = 1; mem_rdata_i = 32'hA000_0000 + k;
      step();
      mem_ack_i = 0;
      tests++;
      if ((exp_dm[k] ? dm_done_o : if_done_o) !== 1'b1
          || (exp_dm[k] ? dm_rdata_o : if_rdata_o) !== 32'hA000_0000 + k) begin
        fails++;
        $display("FAIL tie_done_%0d: done if/dm=%b%b rdata if/dm=%h/%h want port %0d data %h", k,
                 if_done_o, dm_done_o, if_rdata_o, dm_rdata_o, exp_dm[k], 32'hA000_0000 + k);
      end
      if (exp_dm[k]) dm_req_i = 0;
      else begin
        if_req_i = 0;
        step();
      end
    end
    // The IF request left over from the third tie is served next; drain it.
    step();
    mem_ack_i = 1;
    step();
    mem_ack_i = 0; if_req_i = 0;
    step();
  endtask

  task automatic test_dm_write();
    logic [DW-1:0] old_rdata;
    int            pulses;
    old_rdata = dm_rdata_o;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h40; dm_wdata_i = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      tests++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || mem_addr_o !== 32'h40
          || dm_done_o !== 1'b0 || dm_stall_o !== 1'b1) begin
        fails++;
        $display("FAIL dm_write_c%0d: req=%b we=%b wdata=%h addr=%h done=%b stall=%b want 1 1 deadbeef 40 0 1",
                 c, mem_req_o, mem_we_o, mem_wdata_o, mem_addr_o, dm_done_o, dm_stall_o);
      end
      if (c == 4) begin mem_ack_i = 1; mem_rdata_i = 32'h1234_5678; end
    end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_ack_i = 0;
      dm_req_i = 0;
      if (dm_done_o) pulses++;
    end
    tests++;
    if (pulses != 1 || dm_rdata_o !== old_rdata || mem_req_o !== 1'b0) begin
      fails++;
      $display("FAIL dm_write_done: pulses=%0d rdata=%h req=%b want 1 %h 0", pulses, dm_rdata_o, mem_req_o, old_rdata);
    end
  endtask

  task automatic test_hold_through_done();
    int req_cycles;
    req_cycles = 0;
    if_req_i = 1; if_addr_i = 32'h80;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (mem_req_o) req_cycles++;
      mem_ack_i = (c == 1);
      if (c == 3) if_req_i = 0;  // high through the done cycle (c == 2), dropped after
    end
    tests++;
    if (req_cycles != 1) begin
      fails++;
      $display("FAIL hold_through_done: mem_req cycles=%0d want 1", req_cycles);
    end
    mem_ack_i = 0;
  endtask

  task automatic test_random();
    bit            busy, cur_dm, last_dm, exp_req, exp_we, exp_ifd, exp_dmd;
    bit            if_elig, dm_elig, if_drop_next, dm_drop_next;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_ifr, exp_dmr;
    int            wait_left;
    apply_reset();
    busy = 0; last_dm = 0; exp_req = 0; exp_ifd = 0; exp_dmd = 0; exp_we = 0;
    if_drop_next = 0; dm_drop_next = 0; exp_ifr = '0; exp_dmr = '0; wait_left = 0;
    exp_addr = '0; exp_wdata = '0; cur_dm = 0;
    for (int n = 0; n < 600; n++) begin
      tests++;
      if (mem_req_o !== exp_req || (exp_req && (mem_addr_o !== exp_addr || mem_we_o !== exp_we
          || (exp_we && mem_wdata_o !== exp_wdata)))) begin
        fails++;
        $display("FAIL rand_mem_%0d: req=%b addr=%h we=%b wdata=%h want %b %h %b %h", n, mem_req_o,
                 mem_addr_o, mem_we_o, mem_wdata_o, exp_req, exp_addr, exp_we, exp_wdata);
      end
      tests++;
      if (if_done_o !== exp_ifd || dm_done_o !== exp_dmd || if_rdata_o !== exp_ifr || dm_rdata_o !== exp_dmr
          || if_stall_o !== (if_req_i & ~exp_ifd) || dm_stall_o !== (dm_req_i & ~exp_dmd)
          || err_timeout_o !== 1'b0) begin
        fails++;
        $display("FAIL rand_port_%0d: done=%b%b rdata=%h/%h stall=%b%b err=%b want done=%b%b rdata=%h/%h", n,
                 if_done_o, dm_done_o, if_rdata_o, dm_rdata_o, if_stall_o, dm_stall_o, err_timeout_o,
                 exp_ifd, exp_dmd, exp_ifr, exp_dmr);
      end
      // Requesters: hold until done, drop in or one cycle after the done cycle.
      if (exp_ifd) begin
        if ($urandom_range(1)) if_drop_next = 1; else if_req_i = 0;
      end else if (if_drop_next) begin
        if_req_i = 0; if_drop_next = 0;
      end else if (!if_req_i && $urandom_range(2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (exp_dmd) begin
        if ($urandom_range(1)) dm_drop_next = 1; else dm_req_i = 0;
      end else if (dm_drop_next) begin
        dm_req_i = 0; dm_drop_next = 0;
      end else if (!dm_req_i && $urandom_range(2) == 0) begin
        dm_req_i = 1; dm_addr_i = $urandom; dm_wdata_i = $urandom; dm_we_i = $urandom_range(1);
      end
      if_elig = if_req_i && !exp_ifd;
      dm_elig = dm_req_i && !exp_dmd;
      exp_ifd = 0; exp_dmd = 0;
      mem_ack_i = 0; mem_rdata_i = $urandom;
      if (busy) begin
        if (wait_left == 0) begin
          mem_ack_i = 1; busy = 0; exp_req = 0;
          if (cur_dm) begin
            exp_dmd = 1;
            if (!exp_we) exp_dmr = mem_rdata_i;
          end else begin
            exp_ifd = 1; exp_ifr = mem_rdata_i;
          end
        end else wait_left--;
      end else begin
        // Stray acks while idle must be ignored.
        mem_ack_i = ($urandom_range(3) == 0);
        if (if_elig || dm_elig) begin
          cur_dm = dm_elig && (!if_elig || !last_dm);
          last_dm = cur_dm; busy = 1; exp_req = 1; wait_left = $urandom_range(4);
          exp_addr = cur_dm ? dm_addr_i : if_addr_i;
          exp_we = cur_dm ? dm_we_i : 1'b0;
          exp_wdata = dm_wdata_i;
        end
      end
      step();
    end
  endtask

  task automatic test_timeout_reset();
    apply_reset();
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h500;
    for (int c = 1; c <= 12; c++) begin
      step();
      tests++;
      if (mem_req_o !== 1'b1 || err_timeout_o !== (c >= 9)) begin
        fails++;
        $display("FAIL timeout_c%0d: req=%b err=%b want 1 %b", c, mem_req_o, err_timeout_o, c >= 9);
      end
    end
    #2 rst_i = 0;
    #1;
    tests++;
    if ({mem_req_o, mem_we_o, if_done_o, dm_done_o, err_timeout_o} !== 5'b0 || mem_addr_o !== '0
        || mem_wdata_o !== '0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
      fails++;
      $display("FAIL midreset: req=%b we=%b done=%b%b err=%b addr=%h want all 0",
               mem_req_o, mem_we_o, if_done_o, dm_done_o, err_timeout_o, mem_addr_o);
    end
    @(negedge clk);
    clear_inputs();
    rst_i = 1;
    step();
    tests++;
    if (mem_req_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_idle: req=%b err=%b want 0 0", mem_req_o, err_timeout_o);
    end
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_if_read();
    test_tie_rr();
    test_dm_write();
    test_hold_through_done();
    test_random();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
